// File: rtl/data_mem_mover.sv
// data_mem_mover
//   Avalon-MM master that fills or copies word regions of the single-port
//   data RAM. It accepts one command at a time over valid/ready and pulses
//   done for one cycle when the command completes.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while idle)
//   cmd_op              0 = fill, 1 = copy
//   cmd_src, cmd_dst    start word addresses (src used by copy only)
//   cmd_len             word count, 0 .. 2^ADDR_W
//   cmd_pattern         fill value (used by fill only)
//   busy, done          status: busy from accept through done, done pulse
//   avm_*               RAM slave port; avm_readdata has one-cycle latency
//   checksum            (DATA_MEM_MOVER_CHECKSUM_EN only) modulo sum of every
//                       word written by the last command
//
// Build option
//   DATA_MEM_MOVER_CHECKSUM_EN  adds the checksum output and its accumulator.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_FILL    | writing the pattern, one word per cycle
// S_COPY_RD | read cycle of a copy pair (source word on the bus)
// S_COPY_WR | write cycle of a copy pair (read data forwarded to the RAM)
// S_DONE    | one-cycle completion pulse

module data_mem_mover #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata
`ifdef DATA_MEM_MOVER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_COPY_RD,
    S_COPY_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  // Words still to be written after the one currently on the bus.
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                accept;

  // ready_q tracks the IDLE state one cycle late, so it is low while reset
  // is asserted and rises on the first clock after reset is released.
  assign accept = (state_q == S_IDLE) && ready_q && cmd_valid;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          busy_d  = 1'b1;
          ready_d = 1'b0;
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          pat_d   = cmd_pattern;
          rem_d   = cmd_len - 1'b1;
          if (cmd_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!cmd_op) begin
            // First fill word goes on the bus in the cycle right after accept.
            state_d = S_FILL;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = cmd_dst;
            wdata_d = cmd_pattern;
            dst_d   = cmd_dst + 1'b1;
          end else begin
            state_d = S_COPY_RD;
            cs_d    = 1'b1;
            addr_d  = cmd_src;
            src_d   = cmd_src + 1'b1;
          end
        end
      end

      S_FILL: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = pat_q;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
        end
      end

      S_COPY_RD: begin
        state_d = S_COPY_WR;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_q;
        dst_d   = dst_q + 1'b1;
      end

      S_COPY_WR: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_COPY_RD;
          cs_d    = 1'b1;
          addr_d  = src_q;
          src_d   = src_q + 1'b1;
          rem_d   = rem_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign cmd_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = {(DATA_W/8){cs_q}};
  assign avm_clken      = 1'b1;
  // Read data only arrives in the write cycle itself, so a copy write
  // forwards it straight from the RAM instead of through a register.
  assign avm_writedata  = (state_q == S_COPY_WR) ? avm_readdata : wdata_q;

`ifdef DATA_MEM_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // A word counts at the edge where the RAM commits it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (cs_q && wr_q) begin
      sum_q <= sum_q + avm_writedata;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: doc/data_mem_mover.md
# data_mem_mover

Avalon-MM master that fills or copies word regions of the 1024×32 single-port data RAM on behalf of the Nios-side control logic, e.g. clearing a frame buffer or duplicating sprite tables without CPU load. Accepts one command at a time over a valid/ready handshake and drives the RAM's slave port (chipselect, write, byteenable, 10-bit word address, 32-bit data) with the fixed timing that memory imposes. Signals completion with a one-cycle done pulse.

## Interface
- ADDR_W, 10, word-address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable is DATA_W/8 bits
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = fill, 1 = copy
- cmd_src  in  ADDR_W  copy source start word address (ignored for fill)
- cmd_dst  in  ADDR_W  destination start word address
- cmd_len  in  ADDR_W+1  word count, 0..1024
- cmd_pattern  in  DATA_W  fill value (ignored for copy)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at completion
- avm_address  out  ADDR_W  word address to RAM
- avm_chipselect  out  1  bus access this cycle
- avm_write  out  1  write strobe (qualified by chipselect)
- avm_byteenable  out  DATA_W/8  always all-ones when chipselect high, else 0
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  constant 1 after reset
- avm_readdata  in  DATA_W  RAM read data, valid exactly 1 cycle after read address cycle

## Operation
- States: IDLE, FILL, COPY_RD, COPY_WR, DONE.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all cmd_* fields; len=0 -> DONE; op=0 -> FILL; op=1 -> COPY_RD.
- FILL: each cycle write pattern to dst, dst++, remaining--; remaining reaches 0 -> DONE.
- COPY_RD: chipselect=1, write=0, address=src; src++ -> COPY_WR.
- COPY_WR: chipselect=1, write=1, address=dst, writedata=avm_readdata; dst++, remaining--; remaining 0 -> DONE else COPY_RD.
- DONE: done=1 for one cycle, -> IDLE.
- Address arithmetic modulo 2^ADDR_W: region crossing 1023 wraps to 0.
- Copy strictly ascending, one word read then written; overlapping regions with dst > src propagate already-written words (defined behaviour, not an error).
- No waitrequest: slave has fixed latency; master never stalls.

## Timing
- Reset values: cmd_ready=0 during reset, 1 first cycle after; busy=0, done=0, avm_chipselect=0, avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0, avm_clken=1; state IDLE.
- Outputs registered. Accept at edge T0; first bus cycle is T0+1.
- Fill of N words: writes at T0+1..T0+N, done at T0+N+1; cmd_ready back at T0+N+2.
- Copy of N words: read at T0+2k+1, write at T0+2k+2 (k=0..N-1), done at T0+2N+1.
- len=0: no bus activity, done at T0+1.
- busy high from T0+1 through done cycle inclusive.
- cmd_valid while busy ignored (cmd_ready=0); no queuing.
- reset mid-operation: at next edge all outputs to reset values, no further bus cycles, no done pulse; partially written region left as-is.

## Configuration
- DATA_MEM_MOVER_CHECKSUM_EN defined: adds output checksum [DATA_W-1:0], additive modulo 2^DATA_W sum of every word written by the last command; cleared on command accept and reset; stable and valid from done cycle until next accept.
- Undefined: no checksum port, no accumulator logic.

## Test plan
- Fill dst=0x010, len=4, pattern=0xDEADBEEF -> writes at 0x010..0x013 on 4 consecutive cycles, done at T0+5, RAM words read back 0xDEADBEEF.
- Copy src=0x000 (preloaded 1,2,3), dst=0x100, len=3 -> alternating read/write cycles, 0x100..0x102 = 1,2,3, done at T0+7.
- Fill dst=0x3FE, len=4 -> writes to 0x3FE,0x3FF,0x000,0x001; 0x002 unchanged.
- len=0 either op -> no chipselect, done at T0+1; cmd_valid asserted while busy -> ignored, second command runs only after re-presentation in IDLE.
- Reset asserted after 2 of 8 fill writes -> chipselect 0 next cycle, no done, only first 2 words modified.
- With DATA_MEM_MOVER_CHECKSUM_EN: copy of words 0xFFFFFFFF,0x00000002 -> checksum 0x00000001 at done.
